// File: rtl/universal_shift_reg_seq.sv
// universal_shift_reg_seq: command-driven universal shift register.
// Executes multi-step shift/rotate commands under a start/busy/done handshake.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start, mode, count  - command request, operation code, step count
//   p_din               - parallel load data
//   s_left_din          - serial input entering the LSB on left shifts
//   s_right_din         - serial input entering the MSB on right shifts
//   p_dout              - register contents
//   s_left_dout         - p_dout MSB
//   s_right_dout        - p_dout LSB
//   busy                - multi-step command in progress
//   done                - single-cycle completion pulse
module universal_shift_reg_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;

  // One single-bit step of the latched operation.
  always_comb begin
    step_val = data_q;
    case (mode_q)
      M_SHR:   step_val = {s_right_din, data_q[WIDTH-1:1]};
      M_SHL:   step_val = {data_q[WIDTH-2:0], s_left_din};
      M_ROR:   step_val = {data_q[0], data_q[WIDTH-1:1]};
      M_ROL:   step_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      M_ASR:   step_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: step_val = data_q;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        if (mode == M_LOAD) begin
          data_d = p_din;
          done_d = 1'b1;
        end else if (mode == M_HOLD || mode == 3'b111 || count == '0) begin
          // Hold, reserved and zero-length commands complete immediately.
          done_d = 1'b1;
        end else begin
          mode_d  = mode;
          rem_d   = count;
          state_d = RUN;
        end
      end
    end else begin
      data_d = step_val;
      rem_d  = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State register; reset has priority over any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign p_dout       = data_q;
  assign s_left_dout  = data_q[WIDTH-1];
  assign s_right_dout = data_q[0];
  assign busy         = (state_q == RUN);
  assign done         = done_q;

endmodule

// File: tb/tb_universal_shift_reg_seq.sv
module tb_universal_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst, start, s_left_din, s_right_din;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] p_din, p_dout;
  logic       s_left_dout, s_right_dout, busy, done;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int m_val = 0;
  int m_left = 0;
  int m_mode = 0;
  bit m_busy = 0;
  bit m_done = 0;

  universal_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
    .p_din(p_din), .s_left_din(s_left_din), .s_right_din(s_right_din),
    .p_dout(p_dout), .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int apply_op(int op, int v, int sl, int sr);
    case (op)
      1: return (v >> 1) | (sr << 7);
      2: return ((v << 1) & 255) | sl;
      4: return (v >> 1) | ((v & 1) << 7);
      5: return ((v << 1) & 255) | (v >> 7);
      6: return (v >> 1) | (v & 128);
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit r, input bit s, input int md, input int cnt,
                     input int pd, input bit sl, input bit sr);
    rst = r; start = s; mode = 3'(md); count = 4'(cnt);
    p_din = 8'(pd); s_left_din = sl; s_right_din = sr;
    if (r) begin
      m_val = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (s) begin
        if (md == 3) begin
          m_val = pd; m_done = 1;
        end else if (md == 0 || md == 7 || cnt == 0) begin
          m_done = 1;
        end else begin
          m_busy = 1; m_left = cnt; m_mode = md;
        end
      end
    end else begin
      m_done = 0;
      m_val = apply_op(m_mode, m_val, int'(sl), int'(sr));
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("p_dout", 32'(p_dout), 32'(m_val));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("s_left_dout", 32'(s_left_dout), 32'((m_val >> 7) & 1));
    chk("s_right_dout", 32'(s_right_dout), 32'(m_val & 1));
  endtask

  task automatic idle(input int n, input bit sl, input bit sr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, sl, sr);
  endtask

  initial begin
    rst = 1; start = 0; mode = 0; count = 0; p_din = 0;
    s_left_din = 0; s_right_din = 0;

    // Reset with a load request pending: command dropped
    cyc(1, 1, 3, 0, 255, 0, 0);
    cyc(1, 1, 3, 0, 255, 0, 0);
    chk("reset_pdout", 32'(p_dout), 32'h0);

    // Load then zero-count shift
    cyc(0, 1, 3, 0, 'hB4, 0, 0);
    chk("load_b4", 32'(p_dout), 32'hB4);
    chk("load_done", 32'(done), 32'h1);
    cyc(0, 1, 1, 0, 0, 1, 1);
    chk("zero_cnt", 32'(p_dout), 32'hB4);
    idle(1, 0, 0);

    // Rotate right by 3
    cyc(0, 1, 4, 3, 0, 0, 0);
    chk("ror_busy", 32'(busy), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("ror1", 32'(p_dout), 32'h5A);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("ror2", 32'(p_dout), 32'h2D);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("ror3", 32'(p_dout), 32'h96);
    chk("ror_done", 32'(done), 32'h1);

    // Rotate left by 11 wraps modulo 8
    cyc(0, 1, 5, 11, 0, 0, 0);
    idle(11, 0, 0);
    chk("rol11", 32'(p_dout), 32'hB4);

    // Arithmetic right from 0x96
    cyc(0, 1, 3, 0, 'h96, 0, 0);
    cyc(0, 1, 6, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("asr1", 32'(p_dout), 32'hCB);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("asr2", 32'(p_dout), 32'hE5);

    // Shift left by 4 with serial ones; back-to-back start in the done cycle
    cyc(0, 1, 2, 4, 0, 1, 0);
    idle(4, 1, 0);
    cyc(0, 1, 1, 2, 0, 0, 1);
    idle(3, 0, 1);

    // Extra starts while busy are ignored
    cyc(0, 1, 1, 5, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 3, 7, 'h55, i[0], ~i[0]);
    idle(2, 0, 0);

    // Reset in the middle of a shift: no done
    cyc(0, 1, 3, 0, 'hF0, 0, 0);
    cyc(0, 1, 1, 6, 0, 0, 0);
    idle(2, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("abort_pdout", 32'(p_dout), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    idle(2, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
